lru_refill_controller: RTL

LRU_REFILL_CONTROLLER -- requirements
Module: lru_refill_controller

---
 rtl/lru_refill_controller_pkg.sv | 29 ++
 rtl/lru_refill_controller_rr_arbiter.sv | 42 ++++
 rtl/lru_refill_controller.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/lru_refill_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lru_refill_controller_pkg
// Description : Shared types for the LRU-driven cache line refill controller.
// Revision    : 1.0
// ============================================================================
package lru_refill_controller_pkg;

  typedef enum logic [2:0] {
    RS_IDLE     = 3'd0,
    RS_VICTIM   = 3'd1,
    RS_MEM_REQ  = 3'd2,
    RS_MEM_WAIT = 3'd3,
    RS_UPDATE   = 3'd4
  } refill_state_e;

  localparam int unsigned DEF_BEAT_NUM        = 4;
  localparam int unsigned DEF_LINE_ADDR_WIDTH = 26;

  typedef logic [$clog2(DEF_BEAT_NUM)-1:0]  beat_idx_t;
  typedef logic [DEF_LINE_ADDR_WIDTH-1:0]   line_addr_t;

  // Index width that never collapses to zero bits for single-entry vectors.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lru_refill_controller_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : refill_rr_arbiter
// Description : Round-robin pick: lowest requester >= pointer, else lowest.
// Revision    : 1.0
// ============================================================================
module refill_rr_arbiter #(
  parameter int unsigned REQ_NUM   = 2,
  parameter int unsigned PTR_WIDTH = 1
) (
  input  logic [REQ_NUM-1:0]   req_i,
  input  logic [PTR_WIDTH-1:0] ptr_i,
  output logic                 grant_valid_o,
  output logic [PTR_WIDTH-1:0] grant_idx_o
);

  logic [REQ_NUM-1:0] w_req_hi;

  // Requests at or above the pointer take priority over wrapped ones.
  genvar gi;
  generate
    for (gi = 0; gi < REQ_NUM; gi++) begin : g_mask
      assign w_req_hi[gi] = req_i[gi] && (PTR_WIDTH'(gi) >= ptr_i);
    end
  endgenerate

  always_comb begin
    grant_valid_o = |req_i;
    grant_idx_o   = '0;
    if (|w_req_hi) begin
      for (int i = REQ_NUM - 1; i >= 0; i--) begin
        if (w_req_hi[i]) grant_idx_o = PTR_WIDTH'(i);
      end
    end else begin
      for (int i = REQ_NUM - 1; i >= 0; i--) begin
        if (req_i[i]) grant_idx_o = PTR_WIDTH'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lru_refill_controller.sv
`default_nettype none
// ============================================================================
// Module      : lru_refill_controller
// Description : Arbitrates cache misses, picks the LRU victim and fills it.
// Revision    : 1.0
// ============================================================================
module lru_refill_controller
  import lru_refill_controller_pkg::*;
#(
  parameter int unsigned REQ_NUM         = 2,
  parameter int unsigned WAY_NUM         = 2,
  parameter int unsigned INDEX_BIT_WIDTH = 1,
  parameter int unsigned LINE_ADDR_WIDTH = 26,
  parameter int unsigned BEAT_NUM        = 4,
  parameter int unsigned DATA_WIDTH      = 32,
  localparam int unsigned REQ_W  = idx_width(REQ_NUM),
  localparam int unsigned WAY_W  = idx_width(WAY_NUM),
  localparam int unsigned BEAT_W = $clog2(BEAT_NUM)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [REQ_NUM-1:0]                            missReq,
  input  logic [REQ_NUM-1:0][INDEX_BIT_WIDTH-1:0]       missIndex,
  input  logic [REQ_NUM-1:0][LINE_ADDR_WIDTH-1:0]       missLineAddr,
  output logic [REQ_NUM-1:0]                            missDone,
  output logic                                          busy,
  output logic [INDEX_BIT_WIDTH-1:0]                    lruIndex,
  input  logic [WAY_W-1:0]                              lruVictimWay,
  output logic                                          lruAccess,
  output logic [WAY_W-1:0]                              lruAccessWay,
  output logic                                          memReqValid,
  input  logic                                          memReqReady,
  output logic [LINE_ADDR_WIDTH-1:0]                    memReqAddr,
  input  logic                                          memRspValid,
  input  logic [DATA_WIDTH-1:0]                         memRspData,
  output logic                                          fillWe,
  output logic [INDEX_BIT_WIDTH-1:0]                    fillIndex,
  output logic [WAY_W-1:0]                              fillWay,
  output logic [BEAT_W-1:0]                             fillBeat,
  output logic [DATA_WIDTH-1:0]                         fillData
);

  localparam logic [2:0] S_IDLE     = RS_IDLE;
  localparam logic [2:0] S_VICTIM   = RS_VICTIM;
  localparam logic [2:0] S_MEM_REQ  = RS_MEM_REQ;
  localparam logic [2:0] S_MEM_WAIT = RS_MEM_WAIT;
  localparam logic [2:0] S_UPDATE   = RS_UPDATE;

  logic [2:0]                 state_q,   state_d;
  logic [REQ_W-1:0]           rr_ptr_q,  rr_ptr_d;
  logic [REQ_W-1:0]           grantee_q, grantee_d;
  logic [INDEX_BIT_WIDTH-1:0] index_q,   index_d;
  logic [LINE_ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic [WAY_W-1:0]           victim_q,  victim_d;
  logic [BEAT_W-1:0]          beat_q,    beat_d;

  logic                       w_grant_valid;
  logic [REQ_W-1:0]           w_grant_idx;
  logic                       w_fill_we;
  logic                       w_update;

  refill_rr_arbiter #(
    .REQ_NUM   (REQ_NUM),
    .PTR_WIDTH (REQ_W)
  ) u_rr_arbiter (
    .req_i         (missReq),
    .ptr_i         (rr_ptr_q),
    .grant_valid_o (w_grant_valid),
    .grant_idx_o   (w_grant_idx)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grantee_d = grantee_q;
    index_d   = index_q;
    addr_d    = addr_q;
    victim_d  = victim_q;
    beat_d    = beat_q;
    case (state_q)
      S_IDLE: begin
        if (w_grant_valid) begin
          state_d   = S_VICTIM;
          grantee_d = w_grant_idx;
          index_d   = missIndex[w_grant_idx];
          addr_d    = missLineAddr[w_grant_idx];
          rr_ptr_d  = (w_grant_idx == REQ_W'(REQ_NUM - 1)) ? '0 : w_grant_idx + 1'b1;
        end
      end
      S_VICTIM: begin
        victim_d = lruVictimWay;
        state_d  = S_MEM_REQ;
      end
      S_MEM_REQ: begin
        if (memReqReady) state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        // Counter wraps naturally on the last beat since BEAT_NUM is a power of two.
        if (memRspValid) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == BEAT_W'(BEAT_NUM - 1)) state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      grantee_q <= '0;
      index_q   <= '0;
      addr_q    <= '0;
      victim_q  <= '0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grantee_q <= grantee_d;
      index_q   <= index_d;
      addr_q    <= addr_d;
      victim_q  <= victim_d;
      beat_q    <= beat_d;
    end
  end

  // Outputs are forced low during reset so an abandoned refill leaks nothing.
  assign w_fill_we    = !rst && (state_q == S_MEM_WAIT) && memRspValid;
  assign w_update     = !rst && (state_q == S_UPDATE);

  assign busy         = !rst && (state_q != S_IDLE);
  assign lruIndex     = rst ? '0 : index_q;
  assign lruAccess    = w_update;
  assign lruAccessWay = rst ? '0 : victim_q;
  assign memReqValid  = !rst && (state_q == S_MEM_REQ);
  assign memReqAddr   = rst ? '0 : addr_q;
  assign fillWe       = w_fill_we;
  assign fillIndex    = rst ? '0 : index_q;
  assign fillWay      = rst ? '0 : victim_q;
  assign fillBeat     = rst ? '0 : beat_q;
  assign fillData     = w_fill_we ? memRspData : '0;

  always_comb begin
    missDone = '0;
    if (w_update) missDone[grantee_q] = 1'b1;
  end

endmodule
`default_nettype wire
